// File: rtl/pingpong_pkg.sv
// pingpong_pkg: court geometry, speed limits and flag encodings shared by the
// ball-motion controller, its datapath and the renderer.
package pingpong_pkg;
    localparam int COURT_W          = 640;
    localparam int COURT_H          = 480;
    localparam int PAD_L_X          = 16;
    localparam int PAD_R_X          = 623;
    localparam int PAD_HALF         = 24;
    localparam int SPEED_INIT       = 4;
    localparam int SPEED_MAX        = 12;
    localparam int VY_STEP          = 2;
    localparam int HITS_PER_SPEEDUP = 4;
    localparam int WIN_SCORE        = 11;

    typedef enum logic [1:0] {
        EDG_NONE  = 2'b00,
        EDG_LEFT  = 2'b01,
        EDG_RIGHT = 2'b10
    } edg_t;

    typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} vx_dir_t;
    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} vy_dir_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction
endpackage

// File: rtl/pp_score_keeper.sv
// pp_score_keeper: awards a point on the edge where the ball first leaves play,
// keeps both saturating scores and flags the end of the match.
module pp_score_keeper
    import pingpong_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] edg,
    input  logic [1:0] edg_n,
    input  logic       score_clr,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       match_over
);
    logic       goal;
    logic [3:0] sl_n;
    logic [3:0] sr_n;

    // Looking at the next edg value lets the point land on the same edge as edg itself.
    assign goal = (edg == EDG_NONE) && (edg_n != EDG_NONE);

    always_comb begin
        sl_n = score_clr ? 4'd0 : (goal && edg_n == EDG_RIGHT) ? sat_inc4(score_l) : score_l;
        sr_n = score_clr ? 4'd0 : (goal && edg_n == EDG_LEFT) ? sat_inc4(score_r) : score_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_l    <= 4'd0;
            score_r    <= 4'd0;
            match_over <= 1'b0;
        end else begin
            score_l    <= sl_n;
            score_r    <= sr_n;
            match_over <= (sl_n >= 4'(WIN_SCORE)) || (sr_n >= 4'(WIN_SCORE));
        end
    end
endmodule

// File: rtl/ball_motion_datapath.sv
// ball_motion_datapath: ball position/velocity registers driven by the motion
// controller's strobes, returning collide/edg/Break flags and the scores.
module ball_motion_datapath
    import pingpong_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Initial_ball,
    input  logic       Value_select,
    input  logic       Compute_alter,
    input  logic       Compute_collide,
    input  logic       Halt,
    input  logic       serve_dir,
    input  logic [8:0] pad_l_y,
    input  logic [8:0] pad_r_y,
    input  logic       abort_req,
    input  logic       score_clr,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic       collide,
    output logic [1:0] edg,
    output logic       Break,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       match_over
);
    localparam logic signed [10:0] PL   = 11'(PAD_L_X);
    localparam logic signed [10:0] PR   = 11'(PAD_R_X);
    localparam logic signed [10:0] XMAX = 11'(COURT_W - 1);
    localparam logic signed [10:0] YMAX = 11'(COURT_H - 1);
    localparam logic signed [10:0] XC   = 11'(COURT_W / 2);
    localparam logic signed [10:0] YC   = 11'(COURT_H / 2);
    localparam logic signed [10:0] VY   = 11'(VY_STEP);
    localparam logic signed [10:0] PH   = 11'(PAD_HALF);

    logic              vx_dir, vy_dir;
    logic [3:0]        speed;
    logic [7:0]        hit_cnt;
    logic signed [10:0] ox, oy, xs, xc, nx, ys, ny, pad, dy;
    logic              goal, wall, hit;
    logic [8:0]        pad9;
    logic [7:0]        hit_inc;
    logic [9:0]        x_n;
    logic [8:0]        y_n;
    logic              vx_n, vy_n, col_n;
    logic [3:0]        speed_n;
    logic [7:0]        hit_n;
    logic [1:0]        edg_n;

    always_comb begin
        ox      = Value_select ? $signed({1'b0, ball_x}) : XC;
        oy      = Value_select ? $signed({2'b0, ball_y}) : YC;
        xs      = vx_dir ? ox + $signed({7'b0, speed}) : ox - $signed({7'b0, speed});
        xc      = vx_dir ? ((xs > PR) ? PR : xs) : ((xs < PL) ? PL : xs);
        goal    = vx_dir ? (ox >= PR) : (ox <= PL);
        nx      = goal ? (vx_dir ? XMAX : 11'sd0) : xc;
        ys      = vy_dir ? oy - VY : oy + VY;
        wall    = vy_dir ? (ys <= 11'sd0) : (ys >= YMAX);
        ny      = wall ? (vy_dir ? 11'sd0 : YMAX) : ys;
        pad9    = vx_dir ? pad_r_y : pad_l_y;
        pad     = $signed({2'b0, pad9});
        dy      = ny - pad;
        hit     = (nx == (vx_dir ? PR : PL)) && ((dy < 11'sd0 ? -dy : dy) <= PH);
        hit_inc = (hit_cnt == 8'hFF) ? hit_cnt : hit_cnt + 8'd1;
        x_n     = ball_x;
        y_n     = ball_y;
        vx_n    = vx_dir;
        vy_n    = vy_dir;
        speed_n = speed;
        hit_n   = hit_cnt;
        col_n   = collide;
        edg_n   = edg;
        if (Initial_ball) begin
            x_n     = 10'(COURT_W / 2);
            y_n     = 9'(COURT_H / 2);
            vx_n    = serve_dir;
            vy_n    = DIR_DOWN;
            speed_n = 4'(SPEED_INIT);
            hit_n   = 8'd0;
            col_n   = 1'b0;
            edg_n   = EDG_NONE;
        end else if (Halt) begin
            col_n = collide;
        end else if (Compute_collide) begin
            vx_n    = ~vx_dir;
            vy_n    = (ball_y < pad9) ? DIR_UP : DIR_DOWN;
            hit_n   = hit_inc;
            speed_n = (hit_inc % 8'(HITS_PER_SPEEDUP) == 8'd0 && speed < 4'(SPEED_MAX)) ? speed + 4'd1 : speed;
            col_n   = 1'b0;
        end else if (Compute_alter) begin
            // Once the ball is out, it parks until the controller re-serves.
            if (edg == EDG_NONE) begin
                x_n   = 10'(nx);
                y_n   = 9'(ny);
                vy_n  = wall ? ~vy_dir : vy_dir;
                col_n = hit;
                edg_n = goal ? (vx_dir ? EDG_RIGHT : EDG_LEFT) : EDG_NONE;
            end else begin
                col_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ball_x  <= 10'(COURT_W / 2);
            ball_y  <= 9'(COURT_H / 2);
            vx_dir  <= DIR_LEFT;
            vy_dir  <= DIR_DOWN;
            speed   <= 4'(SPEED_INIT);
            hit_cnt <= 8'd0;
            collide <= 1'b0;
            edg     <= EDG_NONE;
            Break   <= 1'b0;
        end else begin
            ball_x  <= x_n;
            ball_y  <= y_n;
            vx_dir  <= vx_n;
            vy_dir  <= vy_n;
            speed   <= speed_n;
            hit_cnt <= hit_n;
            collide <= col_n;
            edg     <= edg_n;
            Break   <= !Initial_ball && (Break || abort_req);
        end
    end

    pp_score_keeper u_score (
        .clk       (clk),
        .rst_n     (rst_n),
        .edg       (edg),
        .edg_n     (edg_n),
        .score_clr (score_clr),
        .score_l   (score_l),
        .score_r   (score_r),
        .match_over(match_over)
    );
endmodule

// File: tb/tb_ball_motion_datapath.sv
// tb_ball_motion_datapath: table of strobe sequences with anchored expectations,
// a behavioural reference model and a scoreboard queue checked after each edge.
module tb_ball_motion_datapath;
    localparam logic [3:0] IB = 4'b1000, HA = 4'b0100, CC = 4'b0010, CA = 4'b0001, ID = 4'b0000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Initial_ball = 1'b0, Value_select = 1'b0, Compute_alter = 1'b0;
    logic       Compute_collide = 1'b0, Halt = 1'b0, serve_dir = 1'b0;
    logic [8:0] pad_l_y = 9'd0, pad_r_y = 9'd0;
    logic       abort_req = 1'b0, score_clr = 1'b0;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       collide, Break, match_over;
    logic [1:0] edg;
    logic [3:0] score_l, score_r;

    ball_motion_datapath dut (
        .clk(clk), .rst_n(rst_n), .Initial_ball(Initial_ball), .Value_select(Value_select),
        .Compute_alter(Compute_alter), .Compute_collide(Compute_collide), .Halt(Halt),
        .serve_dir(serve_dir), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y), .abort_req(abort_req),
        .score_clr(score_clr), .ball_x(ball_x), .ball_y(ball_y), .collide(collide), .edg(edg),
        .Break(Break), .score_l(score_l), .score_r(score_r), .match_over(match_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    x, y, c, e, b, sl, sr, mo;
    } exp_t;

    typedef struct {
        string      tag;
        logic [3:0] cmd;
        logic       vs, sd, ab, clr;
        int         pl, pr, reps, ax, ay, ac, ae;
    } vec_t;

    exp_t q[$];
    exp_t got;
    vec_t tbl[$];
    int   n_cmp = 0, n_bad = 0;
    int   mx, my, mvx, mvy, mspd, mhit, mcol, medg, mbrk, msl, msr;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_now(input string t, input int x, y, c, e, b, sl, sr, mo);
        chk({t, ".x"}, int'(ball_x), x);
        chk({t, ".y"}, int'(ball_y), y);
        chk({t, ".collide"}, int'(collide), c);
        chk({t, ".edg"}, int'(edg), e);
        chk({t, ".Break"}, int'(Break), b);
        chk({t, ".score_l"}, int'(score_l), sl);
        chk({t, ".score_r"}, int'(score_r), sr);
        chk({t, ".match_over"}, int'(match_over), mo);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            got = q.pop_front();
            chk_now(got.tag, got.x, got.y, got.c, got.e, got.b, got.sl, got.sr, got.mo);
        end
    end

    task automatic mreset();
        mx = 320; my = 240; mvx = 0; mvy = 0; mspd = 4; mhit = 0;
        mcol = 0; medg = 0; mbrk = 0; msl = 0; msr = 0;
    endtask

    task automatic model(input logic [3:0] cmd, input logic vs, sd, ab, clr, input int pl, pr);
        int ox, oy, nx, ny, pad, e0;
        e0 = medg;
        if (cmd[3]) begin
            mx = 320; my = 240; mvx = int'(sd); mvy = 0; mspd = 4; mhit = 0; mcol = 0; medg = 0;
        end else if (cmd[2]) begin
            mcol = mcol;
        end else if (cmd[1]) begin
            pad = (mvx == 1) ? pr : pl;
            mvy = (my < pad) ? 1 : 0;
            mvx = 1 - mvx;
            if (mhit < 255) mhit++;
            if (mhit % 4 == 0 && mspd < 12) mspd++;
            mcol = 0;
        end else if (cmd[0]) begin
            if (medg != 0) mcol = 0;
            else begin
                ox = vs ? mx : 320;
                oy = vs ? my : 240;
                if (mvx == 0) begin
                    if (ox > 16) begin nx = ox - mspd; if (nx < 16) nx = 16; end
                    else begin nx = 0; medg = 1; end
                end else begin
                    if (ox < 623) begin nx = ox + mspd; if (nx > 623) nx = 623; end
                    else begin nx = 639; medg = 2; end
                end
                if (mvy == 0) begin ny = oy + 2; if (ny >= 479) begin ny = 479; mvy = 1; end end
                else begin ny = oy - 2; if (ny <= 0) begin ny = 0; mvy = 0; end end
                pad = (mvx == 1) ? pr : pl;
                mcol = (((mvx == 0 && nx == 16) || (mvx == 1 && nx == 623)) &&
                        (ny - pad <= 24) && (pad - ny <= 24)) ? 1 : 0;
                mx = nx;
                my = ny;
            end
        end
        mbrk = cmd[3] ? 0 : (ab ? 1 : mbrk);
        if (clr) begin msl = 0; msr = 0; end
        else if (e0 == 0 && medg != 0) begin
            if (medg == 1) msr = (msr < 15) ? msr + 1 : 15;
            else msl = (msl < 15) ? msl + 1 : 15;
        end
    endtask

    // Drives one strobe cycle and queues what the outputs must show after the edge.
    task automatic step(input string tag, input logic [3:0] cmd, input logic vs, sd, ab, clr,
                        input int pl, pr, ax, ay, ac, ae);
        exp_t e;
        @(negedge clk);
        {Initial_ball, Halt, Compute_collide, Compute_alter} = cmd;
        Value_select = vs; serve_dir = sd; abort_req = ab; score_clr = clr;
        pad_l_y = 9'(pl); pad_r_y = 9'(pr);
        model(cmd, vs, sd, ab, clr, pl, pr);
        e.tag = tag;
        e.x  = (ax >= 0) ? ax : mx;
        e.y  = (ay >= 0) ? ay : my;
        e.c  = (ac >= 0) ? ac : mcol;
        e.e  = (ae >= 0) ? ae : medg;
        e.b  = mbrk; e.sl = msl; e.sr = msr;
        e.mo = (msl >= 11 || msr >= 11) ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic run(input vec_t v);
        for (int r = 0; r < v.reps; r++) begin
            if (r == v.reps - 1) step(v.tag, v.cmd, v.vs, v.sd, v.ab, v.clr, v.pl, v.pr, v.ax, v.ay, v.ac, v.ae);
            else step(v.tag, v.cmd, v.vs, v.sd, v.ab, v.clr, v.pl, v.pr, -1, -1, -1, -1);
        end
    endtask

    task automatic settle();
        step("idle", ID, 1'b1, 1'b0, 1'b0, 1'b0, 300, 300, -1, -1, -1, -1);
        @(posedge clk);
        #2;
    endtask

    task automatic miss_left(input string tag, input logic clr_on_goal);
        step(tag, IB, 1'b1, 1'b0, 1'b0, 1'b0, 300, 300, 320, 240, 0, 0);
        for (int i = 0; i < 76; i++) step(tag, CA, 1'b1, 1'b0, 1'b0, 1'b0, 300, 300, -1, -1, -1, -1);
        step(tag, CA, 1'b1, 1'b0, 1'b0, clr_on_goal, 300, 300, 0, 394, 0, 1);
    endtask

    initial begin
        mreset();
        tbl.push_back('{"serve", IB,      1'b1, 1'b1, 1'b0, 1'b0, 300, 300,  1, 320, 240, 0, 0});
        tbl.push_back('{"alt1",  CA,      1'b1, 1'b1, 1'b0, 1'b0, 300, 300,  1, 324, 242, 0, 0});
        tbl.push_back('{"srvL",  IB,      1'b1, 1'b0, 1'b0, 1'b0, 380, 0,    1, 320, 240, 0, 0});
        tbl.push_back('{"runL",  CA,      1'b1, 1'b0, 1'b0, 1'b0, 380, 0,   75,  20, 390, 0, 0});
        tbl.push_back('{"hitL",  CA,      1'b1, 1'b0, 1'b0, 1'b0, 380, 0,    1,  16, 392, 1, 0});
        tbl.push_back('{"coll",  CC,      1'b1, 1'b0, 1'b0, 1'b0, 380, 0,    1,  16, 392, 0, 0});
        tbl.push_back('{"rtrn",  CA,      1'b1, 1'b0, 1'b0, 1'b0, 380, 0,    1,  20, 394, 0, 0});
        tbl.push_back('{"runR",  CA,      1'b1, 1'b0, 1'b0, 1'b0, 380, 0,   42, 188, 478, 0, 0});
        tbl.push_back('{"wall",  CA,      1'b1, 1'b0, 1'b0, 1'b0, 380, 0,    1, 192, 479, 0, 0});
        tbl.push_back('{"bnce",  CA,      1'b1, 1'b0, 1'b0, 1'b0, 380, 0,    1, 196, 477, 0, 0});
        tbl.push_back('{"vs0",   CA,      1'b0, 1'b0, 1'b0, 1'b0, 380, 0,    1, 324, 238, 0, 0});
        tbl.push_back('{"srvL2", IB,      1'b1, 1'b0, 1'b0, 1'b0, 300, 300,  1, 320, 240, 0, 0});
        tbl.push_back('{"runL2", CA,      1'b1, 1'b0, 1'b0, 1'b0, 300, 300, 76,  16, 392, 0, 0});
        tbl.push_back('{"missL", CA,      1'b1, 1'b0, 1'b0, 1'b0, 300, 300,  1,   0, 394, 0, 1});
        tbl.push_back('{"holdL", CA,      1'b1, 1'b0, 1'b0, 1'b0, 300, 300,  2,   0, 394, 0, 1});
        tbl.push_back('{"srvR",  IB,      1'b1, 1'b1, 1'b0, 1'b0, 0,   0,    1, 320, 240, 0, 0});
        tbl.push_back('{"halt",  HA | CA, 1'b1, 1'b1, 1'b0, 1'b0, 0,   0,    1, 320, 240, 0, 0});
        tbl.push_back('{"runR2", CA,      1'b1, 1'b1, 1'b0, 1'b0, 0,   0,   76, 623, 392, 0, 0});
        tbl.push_back('{"missR", CA,      1'b1, 1'b1, 1'b0, 1'b0, 0,   0,    1, 639, 394, 0, 2});
        tbl.push_back('{"srvS",  IB,      1'b1, 1'b1, 1'b0, 1'b0, 0,   0,    1, 320, 240, 0, 0});
        tbl.push_back('{"c4",    CC,      1'b1, 1'b1, 1'b0, 1'b0, 0,   0,    4, 320, 240, 0, 0});
        tbl.push_back('{"spd5",  CA,      1'b1, 1'b1, 1'b0, 1'b0, 0,   0,    1, 325, 242, 0, 0});
        tbl.push_back('{"c32",   CC,      1'b1, 1'b1, 1'b0, 1'b0, 0,   0,   28, 325, 242, 0, 0});
        tbl.push_back('{"spd12", CA,      1'b1, 1'b1, 1'b0, 1'b0, 0,   0,    1, 337, 244, 0, 0});
        tbl.push_back('{"c36",   CC,      1'b1, 1'b1, 1'b0, 1'b0, 0,   0,    4, 337, 244, 0, 0});
        tbl.push_back('{"spdmx", CA,      1'b1, 1'b1, 1'b0, 1'b0, 0,   0,    1, 349, 246, 0, 0});
        tbl.push_back('{"abort", ID,      1'b1, 1'b1, 1'b1, 1'b0, 0,   0,    1, 349, 246, 0, 0});
        tbl.push_back('{"brkhd", CA,      1'b1, 1'b1, 1'b0, 1'b0, 0,   0,   10, 469, 266, 0, 0});
        tbl.push_back('{"brkcl", IB,      1'b1, 1'b0, 1'b0, 1'b0, 0,   0,    1, 320, 240, 0, 0});
        tbl.push_back('{"prio1", IB | HA | CC | CA, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1, 320, 240, 0, 0});
        tbl.push_back('{"prio2", HA | CC | CA, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0,    1, 320, 240, 0, 0});
        tbl.push_back('{"prio3", CC | CA, 1'b1, 1'b1, 1'b0, 1'b0, 0,   0,    1, 320, 240, 0, 0});
        tbl.push_back('{"prio4", CA,      1'b1, 1'b1, 1'b0, 1'b0, 0,   0,    1, 316, 242, 0, 0});

        #7;
        chk_now("reset0", 320, 240, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run(tbl[i]);

        for (int i = 0; i < 15; i++) miss_left("misses", 1'b0);
        settle();
        chk("sat.score_r", int'(score_r), 15);
        chk("sat.score_l", int'(score_l), 1);
        chk("sat.match_over", int'(match_over), 1);

        step("clr", ID, 1'b1, 1'b0, 1'b0, 1'b1, 300, 300, -1, -1, -1, -1);
        miss_left("clrgoal", 1'b1);
        settle();
        chk("clrgoal.score_r", int'(score_r), 0);
        chk("clrgoal.match_over", int'(match_over), 0);

        miss_left("again", 1'b0);
        step("abort2", ID, 1'b1, 1'b0, 1'b1, 1'b0, 300, 300, 0, 394, 0, 1);
        settle();
        chk("pre_rst.score_r", int'(score_r), 1);
        chk("pre_rst.Break", int'(Break), 1);

        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk_now("async_rst", 320, 240, 0, 0, 0, 0, 0, 0);
        {Initial_ball, Halt, Compute_collide, Compute_alter} = ID;
        mreset();
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", CA, 1'b1, 1'b0, 1'b0, 1'b0, 300, 300, 316, 242, 0, 0);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ball_motion_datapath.md
# ball_motion_datapath

Datapath partner of the ball-motion controller FSM. It consumes the controller's strobes (Initial_ball, Value_select, Compute_alter, Compute_collide, Halt) and returns the status flags that FSM branches on (collide, edg, Break). It holds ball position, velocity, rally hit count and both players' scores. It sits between the controller, the paddle-position inputs decoded from the 52-MCU motion sensors, and the VGA renderer.

## Interface
- COURT_W, 640, court width in pixels; x range 0..COURT_W-1
- COURT_H, 480, court height; y range 0..COURT_H-1
- PAD_L_X, 16, x of left paddle plane
- PAD_R_X, 623, x of right paddle plane
- PAD_HALF, 24, paddle half-length; hit when |y - pad_y| <= PAD_HALF
- SPEED_INIT, 4, x step per Compute_alter at serve
- SPEED_MAX, 12, x-step saturation
- VY_STEP, 2, y step per Compute_alter
- HITS_PER_SPEEDUP, 4, hits between speed increments
- WIN_SCORE, 11, score at which match_over asserts
- clk  in  1  game clock; sole clock
- rst_n  in  1  reset; asynchronous, active-low
- Initial_ball, Value_select, Compute_alter, Compute_collide, Halt  in  1 each  controller strobes
- serve_dir  in  1  0 = serve left, 1 = serve right; sampled on Initial_ball
- pad_l_y, pad_r_y  in  9  paddle centre y
- abort_req  in  1  single-cycle pause/abort from MCU
- score_clr  in  1  clears both scores
- ball_x  out  10  ball x
- ball_y  out  9  ball y
- collide  out  1  ball on paddle plane within paddle span, moving toward it
- edg  out  2  00 in play, 01 ball past left plane, 10 ball past right plane
- Break  out  1  sticky abort flag
- score_l, score_r  out  4  points
- match_over  out  1  either score >= WIN_SCORE

## Operation
- Reset values: ball_x=320, ball_y=240, vx_dir=0, vy_dir=0 (down), speed=SPEED_INIT, hit_cnt=0. All flags and scores are 0.
- Command priority: Initial_ball > Halt > Compute_collide > Compute_alter. Lower commands are ignored in the same cycle.
- Initial_ball sets:
  - x=COURT_W/2, y=COURT_H/2
  - vx_dir=serve_dir, vy_dir=down, speed=SPEED_INIT
  - hit_cnt=0; collide, edg and Break cleared
- Halt freezes position, velocity and flags. Scores and abort latching remain live.
- Compute_alter operand mux:
  - Value_select=0 takes x/y operands from the serve constants (centre).
  - Value_select=1 takes them from the registers.
- Compute_alter, x moving left:
  - If x > PAD_L_X: nx = max(x - speed, PAD_L_X).
  - Otherwise: nx = 0 and edg=01.
- Compute_alter, x moving right (mirror): if x < PAD_R_X, nx = min(x + speed, PAD_R_X); otherwise nx = COURT_W-1 and edg=10.
- Compute_alter, y:
  - ny = y ± VY_STEP.
  - Reaching or crossing 0 or COURT_H-1 clamps to that wall and flips vy_dir.
- Compute_alter with edg already nonzero leaves position unchanged.
- collide is registered with the alter result: nx equals the plane on the moving side and |ny - pad_y| <= PAD_HALF.
- Compute_collide:
  - Flips vx_dir and increments hit_cnt (saturates at 255).
  - Sets vy_dir = up if y < pad_y, else down.
  - When the new hit_cnt is a multiple of HITS_PER_SPEEDUP, speed += 1, capped at SPEED_MAX.
  - Clears collide.
- Scoring:
  - On the 00 -> nonzero transition of edg, the opponent's score increments once (01 -> score_r, 10 -> score_l). Scores saturate at 15.
  - score_clr zeroes both scores; score_clr wins over a simultaneous increment.
- abort_req sets Break on the next edge. Break holds until Initial_ball or reset.

## Timing
- Every output is registered and updates on the clk edge ending the strobe cycle (1-cycle latency).
- The controller samples collide in the cycle after Compute_alter, so collide is valid exactly then.
- edg is seen by the controller one alter-loop later. The hold-at-goal rule keeps the ball stationary meanwhile.
- Arithmetic is done in 11-bit signed; clamps are applied before the register write, so no wrap-around.
- rst_n asserted mid-rally forces reset values immediately. The first strobe after release is honoured on the next edge.

## Structure
- pingpong_pkg holds the shared constants and encodings:
  - court/paddle constants
  - edg codes (EDG_NONE, EDG_LEFT, EDG_RIGHT)
  - direction encodings
  - SPEED_INIT/SPEED_MAX
- These are shared with the controller FSM and the renderer.
- One sub-module: pp_score_keeper (edge detect on edg, two saturating counters, score_clr, match_over).
- Position/velocity update stays in the top module.

## Test plan
- Reset, then Initial_ball with serve_dir=1, then Compute_alter with Value_select=1 -> (320,240), then (324,242); flags 0.
- Left-paddle hit:
  - Stimulus: x=20, moving left, y=110, pad_l_y=100; Compute_alter, then Compute_collide.
  - Response: after the alter, x=16 and collide=1. After the collide, vx right, vy down, hit_cnt=1, collide=0.
- Left miss:
  - Stimulus: x=16, moving left, pad_l_y=300; Compute_alter, then two more alters.
  - Response: x=0 and edg=01. score_r goes 0 -> 1 and holds at 1. x stays 0.
- Bottom wall: y=478 moving down, Compute_alter -> y=479 with vy up; next alter -> y=477.
- Speed-up:
  - 4 Compute_collide -> speed=5.
  - 32 collides -> speed=12; 36 collides -> speed still 12.
- Break and reset:
  - abort_req pulse -> Break=1 next edge, held through 10 alters, cleared by Initial_ball.
  - rst_n low mid-rally -> all outputs return to reset values without a clock edge.
